usb_bus_arbiter: RTL and testbench
==================================

USB_BUS_ARBITER -- requirements
Module: usb_bus_arbiter

Interface
REQ-001 Parameter TURN_CYCLES, 8: consecutive J-state cycles required before granting TX (2 bit times at 4 clk/bit).
REQ-002 Parameter RELEASE_CYCLES, 4: cycles bus_oe stays high after TX finishes.
REQ-003 Parameter TX_TIMEOUT, 64: max cycles from grant to tx_busy rising.
REQ-004 Parameter EOP_SE0_MIN, 6: min consecutive SE0 cycles accepted as EOP.
REQ-005 Parameter range SHALL be 1..255 for all four; internal counters SHALL be 8 bits.
REQ-006 clk  in  1  system clock, all state changes on rising edge.
REQ-007 n_rst  in  1  reset, asynchronous, active-low.
REQ-008 d_plus_in  in  1  synchronized D+ sample.
REQ-009 d_minus_in  in  1  synchronized D- sample.
REQ-010 tx_request  in  1  level, transmitter has a packet (send_data | send_nak).
REQ-011 tx_busy  in  1  transmitter is_txing.
REQ-012 tx_grant  out  1  transmitter may start.
REQ-013 bus_oe  out  1  drive enable for D+/D- tri-state buffers.
REQ-014 rx_enable  out  1  receiver may sample the bus.
REQ-015 tx_timeout  out  1  one-cycle pulse, grant not used in time.
REQ-016 bus_state  out  3  current state encoding.

Function
REQ-017 Line decode: J = (1,0), K = (0,1), SE0 = (0,0), SE1 = (1,1) treated as non-J, non-SE0.
REQ-018 States/encodings: IDLE=0, RX_ACTIVE=1, RX_EOP=2, TURNAROUND=3, TX_ACTIVE=4, TX_RELEASE=5; codes 6,7 SHALL go to IDLE next cycle.
REQ-019 Outputs SHALL be decoded from registered state only: rx_enable=1 in IDLE/RX_ACTIVE/RX_EOP/TURNAROUND; tx_grant=1 only in TX_ACTIVE; bus_oe=1 only in TX_ACTIVE/TX_RELEASE.
REQ-020 IDLE: non-J sample -> RX_ACTIVE next edge; else tx_request=1 with J -> TURNAROUND; bus activity SHALL win over tx_request in the same cycle.
REQ-021 RX_ACTIVE: SE0 -> RX_EOP with SE0 count=1; tx_request ignored.
REQ-022 RX_EOP: SE0 increments count (saturating at 255); J with count >= EOP_SE0_MIN -> IDLE; J or K with count < EOP_SE0_MIN -> RX_ACTIVE (glitch); K with count >= EOP_SE0_MIN -> RX_ACTIVE.
REQ-023 TURNAROUND: entry clears count; each J cycle increments; non-J -> RX_ACTIVE; tx_request=0 -> IDLE; count reaching TURN_CYCLES -> TX_ACTIVE (grant first visible TURN_CYCLES+1 edges after IDLE sees request).
REQ-024 TX_ACTIVE: entry clears count; tracks seen_busy flag; tx_busy rising sets seen_busy; tx_busy falling after seen_busy -> TX_RELEASE; no tx_busy for TX_TIMEOUT cycles -> tx_timeout pulse, TX_RELEASE.
REQ-025 TX_ACTIVE SHALL ignore bus line samples (own drive).
REQ-026 TX_RELEASE: count RELEASE_CYCLES cycles, then IDLE; tx_request during TX_RELEASE SHALL not shorten or extend it.
REQ-027 tx_request held high after TX_RELEASE SHALL re-arbitrate via IDLE -> TURNAROUND (full turnaround repeated).
REQ-028 tx_timeout SHALL be exactly one cycle, registered, asserted on the TX_ACTIVE -> TX_RELEASE edge.

Reset
REQ-029 n_rst=0 SHALL immediately force state IDLE, counters 0, seen_busy 0, tx_grant 0, bus_oe 0, rx_enable 1, tx_timeout 0, bus_state 0, independent of clk.
REQ-030 Reset mid-TX SHALL drop bus_oe without waiting for an edge; first edge after release starts in IDLE.

Verification
REQ-031 IDLE, J, tx_request=1 held -> bus_state 3 after 1 edge, tx_grant=1 and bus_oe=1 at edge 9, rx_enable=0.
REQ-032 TURNAROUND at count 5, K sample -> bus_state 1 next edge, tx_grant never asserted.
REQ-033 RX: K/J data, SE0 for 8 cycles, then J -> IDLE one edge after J; SE0 for 3 cycles then J -> back to RX_ACTIVE.
REQ-034 Grant, tx_busy high 40 cycles then low -> TX_RELEASE, bus_oe high 4 more cycles, then IDLE with bus_oe=0, rx_enable=1.
REQ-035 Grant, tx_busy never rises -> tx_timeout single pulse on 64th TX_ACTIVE cycle, then TX_RELEASE.
REQ-036 n_rst pulsed low in TX_ACTIVE between edges -> bus_oe and tx_grant 0 asynchronously, bus_state 0.

Source files
------------

// File: rtl/usb_bus_arbiter.sv
// Half-duplex USB line arbiter: tracks receive activity and end-of-packet, then
// hands the bus to the local transmitter after a full J-state turnaround.
module usb_bus_arbiter #(
  parameter int unsigned TURN_CYCLES    = 8,
  parameter int unsigned RELEASE_CYCLES = 4,
  parameter int unsigned TX_TIMEOUT     = 64,
  parameter int unsigned EOP_SE0_MIN    = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus_in,
  input  logic       d_minus_in,
  input  logic       tx_request,
  input  logic       tx_busy,
  output logic       tx_grant,
  output logic       bus_oe,
  output logic       rx_enable,
  output logic       tx_timeout,
  output logic [2:0] bus_state
);

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RX_ACTIVE  = 3'd1,
    RX_EOP     = 3'd2,
    TURNAROUND = 3'd3,
    TX_ACTIVE  = 3'd4,
    TX_RELEASE = 3'd5
  } state_t;

  localparam logic [8:0] TURN_LIM = 9'(TURN_CYCLES);
  localparam logic [8:0] REL_LIM  = 9'(RELEASE_CYCLES);
  localparam logic [8:0] TMO_LIM  = 9'(TX_TIMEOUT);
  localparam logic [7:0] EOP_LIM  = 8'(EOP_SE0_MIN);

  state_t     state, state_next;
  logic [7:0] cnt, cnt_next;
  logic [8:0] cnt_inc;
  logic       seen_busy, seen_busy_next;
  logic       timeout_q, timeout_next;
  logic       line_j, line_se0;

  assign line_j   = d_plus_in & ~d_minus_in;
  assign line_se0 = ~d_plus_in & ~d_minus_in;
  assign cnt_inc  = {1'b0, cnt} + 9'd1;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      cnt       <= '0;
      seen_busy <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      seen_busy <= seen_busy_next;
      timeout_q <= timeout_next;
    end
  end

  // Counter is shared between states; every transition sets its entry value.
  always_comb begin
    state_next     = state;
    cnt_next       = cnt;
    seen_busy_next = seen_busy;
    timeout_next   = 1'b0;
    case (state)
      IDLE: begin
        cnt_next       = '0;
        seen_busy_next = 1'b0;
        if (!line_j)         state_next = RX_ACTIVE;
        else if (tx_request) state_next = TURNAROUND;
      end
      RX_ACTIVE: begin
        cnt_next = '0;
        if (line_se0) begin
          state_next = RX_EOP;
          cnt_next   = 8'd1;
        end
      end
      RX_EOP: begin
        if (line_se0) begin
          if (cnt != 8'hFF) cnt_next = cnt_inc[7:0];
        end else begin
          cnt_next   = '0;
          state_next = (line_j && cnt >= EOP_LIM) ? IDLE : RX_ACTIVE;
        end
      end
      TURNAROUND: begin
        if (!line_j) begin
          state_next = RX_ACTIVE;
          cnt_next   = '0;
        end else if (!tx_request) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_inc >= TURN_LIM) begin
          state_next     = TX_ACTIVE;
          cnt_next       = '0;
          seen_busy_next = 1'b0;
        end else begin
          cnt_next = cnt_inc[7:0];
        end
      end
      TX_ACTIVE: begin
        // Line samples are our own drive here, so only tx_busy matters.
        if (tx_busy) begin
          seen_busy_next = 1'b1;
        end else if (seen_busy) begin
          state_next     = TX_RELEASE;
          cnt_next       = '0;
          seen_busy_next = 1'b0;
        end else if (cnt_inc >= TMO_LIM) begin
          state_next   = TX_RELEASE;
          cnt_next     = '0;
          timeout_next = 1'b1;
        end else begin
          cnt_next = cnt_inc[7:0];
        end
      end
      TX_RELEASE: begin
        if (cnt_inc >= REL_LIM) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc[7:0];
        end
      end
      default: begin
        state_next     = IDLE;
        cnt_next       = '0;
        seen_busy_next = 1'b0;
      end
    endcase
  end

  always_comb begin
    tx_grant   = 1'b0;
    bus_oe     = 1'b0;
    rx_enable  = 1'b0;
    case (state)
      IDLE, RX_ACTIVE, RX_EOP, TURNAROUND: rx_enable = 1'b1;
      TX_ACTIVE: begin
        tx_grant = 1'b1;
        bus_oe   = 1'b1;
      end
      TX_RELEASE: bus_oe = 1'b1;
      default: ;
    endcase
    bus_state  = state;
    tx_timeout = timeout_q;
  end

endmodule

// File: tb/tb_usb_bus_arbiter.sv
// Directed-vector bench for usb_bus_arbiter: stimulus queues the expected state
// per edge, a monitor pops and compares just after each rising edge.
module tb_usb_bus_arbiter;

  localparam logic [1:0] LJ   = 2'b10;
  localparam logic [1:0] LK   = 2'b01;
  localparam logic [1:0] LSE0 = 2'b00;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       d_plus_in, d_minus_in, tx_request, tx_busy;
  logic       tx_grant, bus_oe, rx_enable, tx_timeout;
  logic [2:0] bus_state;

  typedef struct packed {
    logic [2:0] st;
    logic       tmo;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    total = 0;
  int    bad   = 0;

  usb_bus_arbiter #(
    .TURN_CYCLES   (8),
    .RELEASE_CYCLES(4),
    .TX_TIMEOUT    (64),
    .EOP_SE0_MIN   (6)
  ) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .d_plus_in (d_plus_in),
    .d_minus_in(d_minus_in),
    .tx_request(tx_request),
    .tx_busy   (tx_busy),
    .tx_grant  (tx_grant),
    .bus_oe    (bus_oe),
    .rx_enable (rx_enable),
    .tx_timeout(tx_timeout),
    .bus_state (bus_state)
  );

  always #5 clk = ~clk;

  // Expected outputs follow the state table: grant in TX_ACTIVE, drive in
  // TX_ACTIVE/TX_RELEASE, receive enabled in the four non-transmit states.
  task automatic check(input string nm, input logic [2:0] st, input logic tmo);
    logic [6:0] got, want;
    got  = {bus_state, tx_grant, bus_oe, rx_enable, tx_timeout};
    want = {st, (st == 3'd4), (st == 3'd4 || st == 3'd5), (st <= 3'd3), tmo};
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got st=%0d grant=%b oe=%b rx=%b tmo=%b, want st=%0d grant=%b oe=%b rx=%b tmo=%b",
               nm, got[6:4], got[3], got[2], got[1], got[0],
               want[6:4], want[3], want[2], want[1], want[0]);
    end
  endtask

  task automatic step(input string nm, input logic [1:0] line, input logic req,
                      input logic busy, input logic [2:0] st, input logic tmo);
    @(negedge clk);
    d_plus_in  = line[1];
    d_minus_in = line[0];
    tx_request = req;
    tx_busy    = busy;
    name_q.push_back(nm);
    exp_q.push_back('{st: st, tmo: tmo});
  endtask

  task automatic steps(input int n, input string nm, input logic [1:0] line,
                       input logic req, input logic busy, input logic [2:0] st);
    for (int i = 0; i < n; i++) step(nm, line, req, busy, st, 1'b0);
  endtask

  // Nine edges from IDLE with J and request held: 8 in TURNAROUND, grant on the 9th.
  task automatic arbitrate(input string nm);
    steps(8, {nm, "_turn"}, LJ, 1'b1, 1'b0, 3'd3);
    step({nm, "_grant"}, LJ, 1'b1, 1'b0, 3'd4, 1'b0);
  endtask

  initial begin : monitor
    exp_t  e;
    string n;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        check(n, e.st, e.tmo);
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    n_rst      = 1'b0;
    d_plus_in  = 1'b1;
    d_minus_in = 1'b0;
    tx_request = 1'b0;
    tx_busy    = 1'b0;
    #2;
    check("reset_state", 3'd0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;

    step("idle_j", LJ, 1'b0, 1'b0, 3'd0, 1'b0);

    // Grant, then transmitter never starts: 64 TX_ACTIVE cycles then timeout.
    arbitrate("arb1");
    steps(63, "tmo_wait", LK, 1'b0, 1'b0, 3'd4);
    step("tmo_pulse", LSE0, 1'b0, 1'b0, 3'd5, 1'b1);
    steps(3, "tmo_release", LK, 1'b0, 1'b0, 3'd5);
    step("tmo_idle", LJ, 1'b0, 1'b0, 3'd0, 1'b0);

    // Normal transmit with request held through release: turnaround repeats.
    arbitrate("arb2");
    steps(40, "tx_busy", LK, 1'b1, 1'b1, 3'd4);
    step("tx_done", LJ, 1'b1, 1'b0, 3'd5, 1'b0);
    steps(3, "tx_release", LJ, 1'b1, 1'b0, 3'd5);
    step("tx_idle", LJ, 1'b1, 1'b0, 3'd0, 1'b0);
    step("rearb", LJ, 1'b1, 1'b0, 3'd3, 1'b0);
    step("turn_drop_req", LJ, 1'b0, 1'b0, 3'd0, 1'b0);

    // Bus activity beats a simultaneous request.
    step("idle_k_with_req", LK, 1'b1, 1'b0, 3'd1, 1'b0);
    step("rx_j_ignore_req", LJ, 1'b1, 1'b0, 3'd1, 1'b0);
    steps(8, "eop_se0x8", LSE0, 1'b0, 1'b0, 3'd2);
    step("eop_j_idle", LJ, 1'b0, 1'b0, 3'd0, 1'b0);

    // Turnaround aborted by K at count 5.
    steps(6, "turn_cnt5", LJ, 1'b1, 1'b0, 3'd3);
    step("turn_k_abort", LK, 1'b1, 1'b0, 3'd1, 1'b0);
    step("rx_k", LK, 1'b0, 1'b0, 3'd1, 1'b0);
    step("rx_j", LJ, 1'b0, 1'b0, 3'd1, 1'b0);
    steps(3, "se0x3", LSE0, 1'b0, 1'b0, 3'd2);
    step("glitch3_j", LJ, 1'b0, 1'b0, 3'd1, 1'b0);
    steps(5, "se0x5", LSE0, 1'b0, 1'b0, 3'd2);
    step("glitch5_j", LJ, 1'b0, 1'b0, 3'd1, 1'b0);
    steps(6, "se0x6_k", LSE0, 1'b0, 1'b0, 3'd2);
    step("eop6_k_rx", LK, 1'b0, 1'b0, 3'd1, 1'b0);
    steps(6, "se0x6_j", LSE0, 1'b0, 1'b0, 3'd2);
    step("eop6_j_idle", LJ, 1'b0, 1'b0, 3'd0, 1'b0);
    step("idle_se1", 2'b11, 1'b0, 1'b0, 3'd1, 1'b0);
    step("rx_se0", LSE0, 1'b0, 1'b0, 3'd2, 1'b0);
    steps(6, "se0_more", LSE0, 1'b0, 1'b0, 3'd2);
    step("eop_back_idle", LJ, 1'b0, 1'b0, 3'd0, 1'b0);

    // Asynchronous reset while transmitting, between clock edges.
    arbitrate("arb3");
    step("tx_pre_rst", LJ, 1'b1, 1'b1, 3'd4, 1'b0);
    @(posedge clk);
    #3;
    n_rst = 1'b0;
    #1;
    check("async_rst_tx", 3'd0, 1'b0);
    @(negedge clk);
    n_rst = 1'b1;
    step("post_rst_idle", LJ, 1'b0, 1'b0, 3'd0, 1'b0);

    @(posedge clk);
    #3;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
